// File: rtl/frame_buffer_writer_if.sv
// Pixel-in / BRAM-write-out bundle for frame_buffer_writer.
// Handshake: a pixel is offered by a one-cycle wr_pixel_i strobe with
// pixel_data_i valid in the same cycle; there is no back-pressure, so
// every strobe is either written or deliberately dropped. Writes leave
// as a one-cycle mem_we_o with mem_addr_o/mem_data_o valid in that cycle.
interface frame_buffer_writer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480
);
  localparam int ADDR_W = $clog2(H_RES * V_RES);

  logic                    frame_start_i;
  logic                    wr_pixel_i;
  logic [2*DATA_WIDTH-1:0] pixel_data_i;
  logic                    mem_we_o;
  logic [ADDR_W:0]         mem_addr_o;
  logic [2*DATA_WIDTH-1:0] mem_data_o;
  logic                    frame_done_o;
  logic                    frame_err_o;
  logic                    disp_bank_o;
  logic [1:0]              fsm_state;

  modport slave (
    input  frame_start_i, wr_pixel_i, pixel_data_i,
    output mem_we_o, mem_addr_o, mem_data_o,
    output frame_done_o, frame_err_o, disp_bank_o, fsm_state
  );

  modport master (
    output frame_start_i, wr_pixel_i, pixel_data_i,
    input  mem_we_o, mem_addr_o, mem_data_o,
    input  frame_done_o, frame_err_o, disp_bank_o, fsm_state
  );
endinterface

// File: rtl/frame_buffer_writer.sv
// Writes captured RGB565 pixels into a frame-buffer BRAM at a running
// raster address, reporting frame completion and short/overflowing frames.
// Optional feature macro: DOUBLE_BUFFER_EN -- ping-pong between two banks
// so the display side always scans the last complete frame.
module frame_buffer_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  frame_buffer_writer_if.slave  bus
);
  localparam int ADDR_W = $clog2(H_RES * V_RES);
  localparam int XW     = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW     = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int PW     = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] lin_q, lin_d;
  logic              bank_q, bank_d;
  logic              disp_q, disp_d;
  logic              ovf_q, ovf_d;     // overflow already reported this frame
  logic              we_q, we_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic [PW-1:0]     data_q, data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic last_col, last_row;
  assign last_col = (x_q == XW'(H_RES - 1));
  assign last_row = (y_q == YW'(V_RES - 1));

  // Next-state and registered-output decode; frame_start_i beats wr_pixel_i.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    lin_d   = lin_q;
    bank_d  = bank_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.frame_start_i) begin
          state_d = S_ACTIVE;
          x_d     = '0;
          y_d     = '0;
          lin_d   = '0;
          ovf_d   = 1'b0;
        end
      end

      S_ACTIVE: begin
        if (bus.frame_start_i) begin
          // Frame restarted before its last pixel: rewrite the same bank.
          err_d = 1'b1;
          x_d   = '0;
          y_d   = '0;
          lin_d = '0;
        end else if (bus.wr_pixel_i) begin
          we_d   = 1'b1;
          addr_d = {bank_q, lin_q};
          data_d = bus.pixel_data_i;
          if (last_col) begin
            x_d = '0;
            if (last_row) begin
              // Final pixel: counters park at zero so lin_addr stays in range.
              y_d     = '0;
              lin_d   = '0;
              done_d  = 1'b1;
              ovf_d   = 1'b0;
              state_d = S_DONE;
`ifdef DOUBLE_BUFFER_EN
              disp_d = bank_q;
              bank_d = ~bank_q;
`endif
            end else begin
              y_d   = y_q + YW'(1);
              lin_d = lin_q + ADDR_W'(1);
            end
          end else begin
            x_d   = x_q + XW'(1);
            lin_d = lin_q + ADDR_W'(1);
          end
        end
      end

      S_DONE: begin
        if (bus.frame_start_i) begin
          state_d = S_ACTIVE;
          x_d     = '0;
          y_d     = '0;
          lin_d   = '0;
          ovf_d   = 1'b0;
        end else if (bus.wr_pixel_i && !ovf_q) begin
          err_d = 1'b1;
          ovf_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      lin_q   <= '0;
      bank_q  <= 1'b0;
      disp_q  <= 1'b0;
      ovf_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      lin_q   <= lin_d;
      bank_q  <= bank_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.mem_we_o     = we_q;
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_data_o   = data_q;
  assign bus.frame_done_o = done_q;
  assign bus.frame_err_o  = err_q;
  assign bus.disp_bank_o  = disp_q;
  assign bus.fsm_state    = state_q;
endmodule

// File: tb/tb_frame_buffer_writer.sv
// Bench for frame_buffer_writer with a small 4x2 frame: directed steps,
// then random strobes/frame starts/resets against a pixel-count model.
module tb_frame_buffer_writer;
  localparam int DW = 8;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = $clog2(H * V);
  localparam int PW = 2 * DW;
  localparam int EW = 1 + AW + PW;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_buffer_writer_if #(.DATA_WIDTH(DW), .H_RES(H), .V_RES(V)) bus ();

  frame_buffer_writer #(.DATA_WIDTH(DW), .H_RES(H), .V_RES(V)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  // counters and scoreboard
  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];

  // reference model: frame status as flags plus pixels written this frame
  bit in_frame   = 0;
  bit frame_full = 0;
  bit ovf_seen   = 0;
  int pix        = 0;
  bit m_bank     = 0;
  bit m_disp     = 0;
  bit m_we, m_done, m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input bit r, input bit fs, input bit wp, input logic [PW-1:0] d);
    m_we = 0; m_done = 0; m_err = 0;
    if (r) begin
      in_frame = 0; frame_full = 0; ovf_seen = 0; pix = 0;
      m_bank = 0; m_disp = 0;
    end else if (fs) begin
      if (in_frame && !frame_full) m_err = 1;
      in_frame = 1; frame_full = 0; ovf_seen = 0; pix = 0;
    end else if (wp && in_frame && !frame_full) begin
      m_we = 1;
      exp_q.push_back({m_bank, AW'(pix), d});
      pix++;
      if (pix == H * V) begin
        m_done = 1;
        frame_full = 1;
`ifdef DOUBLE_BUFFER_EN
        m_disp = m_bank;
        m_bank = ~m_bank;
`endif
      end
    end else if (wp && frame_full && !ovf_seen) begin
      m_err = 1;
      ovf_seen = 1;
    end
  endtask

  // driver: apply one cycle of inputs, then check outputs 1ns after the edge
  task automatic step(input bit r, input bit fs, input bit wp, input logic [PW-1:0] d);
    logic [EW-1:0] e;
    @(negedge clk);
    rst = r;
    bus.frame_start_i = fs;
    bus.wr_pixel_i    = wp;
    bus.pixel_data_i  = d;
    model(r, fs, wp, d);
    @(posedge clk);
    #1;
    chk("mem_we", 32'(bus.mem_we_o), 32'(m_we));
    chk("frame_done", 32'(bus.frame_done_o), 32'(m_done));
    chk("frame_err", 32'(bus.frame_err_o), 32'(m_err));
    chk("disp_bank", 32'(bus.disp_bank_o), 32'(m_disp));
    if (r) begin
      chk("reset_addr", 32'(bus.mem_addr_o), 32'd0);
      chk("reset_data", 32'(bus.mem_data_o), 32'd0);
    end
    if (bus.mem_we_o === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("write_addr", 32'(bus.mem_addr_o), 32'(e[EW-1:PW]));
      chk("write_data", 32'(bus.mem_data_o), 32'(e[PW-1:0]));
    end
  endtask

  task automatic pixel(input logic [PW-1:0] d);
    step(0, 0, 1, d);
  endtask

  task automatic start();
    step(0, 1, 0, '0);
  endtask

  initial begin
    bus.frame_start_i = 0;
    bus.wr_pixel_i    = 0;
    bus.pixel_data_i  = '0;

    // reset state
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);

    // strobes before any frame start: ignored, no error
    for (int i = 0; i < 3; i++) pixel(16'hBEEF);
    step(0, 0, 0, '0);

    // full frame: addresses 0..7, data 0x1000..0x1007, done on the last
    start();
    for (int i = 0; i < H * V; i++) pixel(16'h1000 + 16'(i));
    step(0, 0, 0, '0);

    // overflow: three extra strobes, one error pulse, no writes
    for (int i = 0; i < 3; i++) pixel(16'hDEAD);

    // short frame: 5 strobes, restart, next strobe lands at address 0
    start();
    for (int i = 0; i < 5; i++) pixel(16'h2000 + 16'(i));
    start();
    for (int i = 0; i < H * V; i++) pixel(16'h3000 + 16'(i));
    step(0, 0, 0, '0);

    // frame start and strobe together in mid-frame: pixel dropped, error
    start();
    pixel(16'h4000);
    step(0, 1, 1, 16'h4001);
    pixel(16'h4002);

    // reset after pixel 3, strobes ignored, then restart at address 0
    start();
    for (int i = 0; i < 3; i++) pixel(16'h5000 + 16'(i));
    step(1, 0, 1, 16'h5003);
    pixel(16'h5004);
    pixel(16'h5005);
    start();
    for (int i = 0; i < H * V; i++) pixel(16'h6000 + 16'(i));

    // random traffic
    for (int i = 0; i < 800; i++) begin
      bit r, fs, wp;
      r  = ($urandom_range(0, 199) == 0);
      fs = ($urandom_range(0, 29) == 0);
      wp = ($urandom_range(0, 99) < 70);
      step(r, fs, wp, 16'($urandom));
    end

    step(0, 0, 0, '0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frame_buffer_writer.md
# frame_buffer_writer

Consumes the 16-bit pixel write strobes produced by the camera pixel capture stage and writes each pixel into a frame-buffer BRAM at a linear raster address. It tracks column/row position, flags frames whose pixel count is short or overflows, and reports frame completion. It optionally ping-pongs between two frame banks so the HDMI read side always scans a complete frame.

## Interface
Parameters:
- DATA_WIDTH, 8, camera byte width; pixel width is 2*DATA_WIDTH
- H_RES, 640, active pixels per line
- V_RES, 480, active lines per frame
- ADDR_W, derived localparam, $clog2(H_RES*V_RES); not overridable

Ports:
- clk_i  in  1  system clock; same domain as the capture stage outputs
- reset_i  in  1  synchronous, active-high reset
- frame_start_i  in  1  one-cycle pulse at camera VSYNC falling edge, already in clk_i domain
- wr_pixel_i  in  1  one-cycle pixel-valid strobe from the capture stage
- pixel_data_i  in  2*DATA_WIDTH  RGB565 pixel, valid with wr_pixel_i
- mem_we_o  out  1  BRAM write enable
- mem_addr_o  out  ADDR_W+1  BRAM address; MSB is bank select
- mem_data_o  out  2*DATA_WIDTH  BRAM write data
- frame_done_o  out  1  one-cycle pulse, last pixel of a full frame written
- frame_err_o  out  1  one-cycle pulse, short frame or overflow detected
- disp_bank_o  out  1  bank holding the most recent complete frame

## Operation
- State machine: IDLE, ACTIVE, DONE. Reset state IDLE.
- IDLE: wr_pixel_i ignored, no error. frame_start_i → ACTIVE, x=0, y=0, lin_addr=0.
- ACTIVE, wr_pixel_i: write pixel_data_i at {bank, lin_addr}. lin_addr += 1. x += 1. If x==H_RES-1, x wraps to 0 and y += 1.
- ACTIVE, write at x==H_RES-1 and y==V_RES-1: pulse frame_done_o, enter DONE.
- ACTIVE, frame_start_i before the last pixel: short frame. Pulse frame_err_o, clear x/y/lin_addr, stay ACTIVE. Bank is unchanged and partial data is overwritten.
- DONE, frame_start_i: → ACTIVE with cleared counters.
- DONE, wr_pixel_i: overflow. Pixel is discarded, mem_we_o stays 0. frame_err_o pulses on the first extra pixel only, once per frame.
- frame_start_i and wr_pixel_i in the same cycle: frame_start_i has priority, and the pixel is dropped. In ACTIVE mid-frame this also counts as a short frame and raises frame_err_o.
- Address is a running counter with no multiplier. lin_addr never exceeds H_RES*V_RES-1.
- reset_i mid-frame: all state cleared next edge, no further writes until a new frame_start_i.

## Timing
- Reset values: mem_we_o=0, mem_addr_o=0, mem_data_o=0, frame_done_o=0, frame_err_o=0, disp_bank_o=0. Internal: bank=0, state IDLE.
- All outputs are registered. A write appears on mem_we_o/mem_addr_o/mem_data_o one cycle after the accepted wr_pixel_i, for exactly one cycle.
- frame_done_o is asserted in the same cycle as mem_we_o for the last pixel.
- frame_err_o is asserted one cycle after the offending frame_start_i or wr_pixel_i.
- Back-to-back wr_pixel_i on consecutive cycles are accepted; there is no throughput limit.
- disp_bank_o and bank update in the same cycle as frame_done_o.

## Configuration
- DOUBLE_BUFFER_EN defined:
  - At the completion of each full frame, disp_bank_o takes the bank just written and the write bank toggles.
  - mem_addr_o MSB equals the write bank.
  - Short frames do not toggle the bank.
- DOUBLE_BUFFER_EN undefined:
  - mem_addr_o MSB and disp_bank_o are constant 0.
  - A single region is overwritten every frame.

## Test plan
- H_RES=4, V_RES=2, frame_start_i then 8 strobes of 0x1000..0x1007 → writes to addresses 0..7 with matching data. frame_done_o pulses with address 7. No frame_err_o.
- Same setup, 5 strobes then frame_start_i → frame_err_o pulses once. The next strobe writes address 0.
- After a full frame, 3 extra strobes → no mem_we_o, frame_err_o pulses exactly once.
- Strobes before any frame_start_i → no writes, no error.
- DOUBLE_BUFFER_EN, two full frames → frame 1 writes MSB=0, frame 2 writes MSB=1. disp_bank_o reads 0 after frame 1 and 1 after frame 2.
- reset_i asserted after pixel 3 → all outputs 0 next cycle. Strobes ignored until frame_start_i, then writing restarts at address 0.
